// File: rtl/wide_cmp_pkg.sv
// Shared types for the nibble-serial wide comparator.
// Result encoding is one-hot {less, equal, greater}.
package wide_cmp_pkg;
   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } cmp_state_e;

   typedef logic [2:0] cmp_res_t;

   localparam cmp_res_t RES_LESS    = 3'b100;
   localparam cmp_res_t RES_EQUAL   = 3'b010;
   localparam cmp_res_t RES_GREATER = 3'b001;
endpackage

// File: rtl/wide_cmp_seq_nibble_cmp.sv
// Combinational 4-bit unsigned magnitude compare; zero latency, no flow control.
// Exactly one of less_o/equal_o/greater_o is high.
module nibble_cmp
   import wide_cmp_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_i,
   input  logic [NIBBLE_W-1:0] b_i,
   output logic                less_o,
   output logic                equal_o,
   output logic                greater_o
);

   assign less_o    = (a_i <  b_i);
   assign equal_o   = (a_i == b_i);
   assign greater_o = (a_i >  b_i);

endmodule

// File: rtl/wide_cmp_seq.sv
// Wide compare by time-sharing one 4-bit slice, MS nibble first, stopping at first difference.
// Latency 1..NIBBLES cycles after accept; result held until out_ready. WIDE_CMP_SIGNED_EN: two's complement.
module wide_cmp_seq
   import wide_cmp_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] data_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] data_b,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        less,
   output logic                        equal,
   output logic                        greater,
   output logic                        busy
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   cmp_state_e       state_q, state_d;
   logic [W-1:0]     opa_q, opa_d;
   logic [W-1:0]     opb_q, opb_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   cmp_res_t         res_q, res_d;
   logic             out_valid_q, out_valid_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b;
   logic [NIBBLE_W-1:0] cmp_a, cmp_b;
   logic                slice_lt, slice_eq, slice_gt;

   assign nib_a = opa_q[{idx_q, 2'b00} +: NIBBLE_W];
   assign nib_b = opb_q[{idx_q, 2'b00} +: NIBBLE_W];

`ifdef WIDE_CMP_SIGNED_EN
   // Flipping the sign bit of the top nibble maps two's complement onto unsigned order.
   logic msn;
   assign msn   = (idx_q == IDX_LAST);
   assign cmp_a = nib_a ^ {msn, 3'b000};
   assign cmp_b = nib_b ^ {msn, 3'b000};
`else
   assign cmp_a = nib_a;
   assign cmp_b = nib_b;
`endif

   nibble_cmp u_slice (
      .a_i       (cmp_a),
      .b_i       (cmp_b),
      .less_o    (slice_lt),
      .equal_o   (slice_eq),
      .greater_o (slice_gt)
   );

   always_comb begin
      state_d     = state_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      idx_d       = idx_q;
      res_d       = res_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opa_d   = data_a;
               opb_d   = data_b;
               idx_d   = IDX_LAST;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (slice_gt) begin
               res_d       = RES_GREATER;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else if (slice_lt) begin
               res_d       = RES_LESS;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else if (slice_eq && idx_q == '0) begin
               res_d       = RES_EQUAL;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               res_d       = '0;
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            res_d       = '0;
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         idx_q       <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         idx_q       <= idx_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign less      = res_q[2];
   assign equal     = res_q[1];
   assign greater   = res_q[0];

endmodule

// File: tb/tb_wide_cmp_seq.sv
// Bench for wide_cmp_seq: a 4-nibble and a 1-nibble instance, directed cases plus random pairs
// checked against an integer-compare reference model.
module tb_wide_cmp_seq;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] data_a = '0, data_b = '0;
   logic         in_ready, out_valid, less, equal, greater, busy;

   logic         in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [3:0]   data_a1 = '0, data_b1 = '0;
   logic         in_ready1, out_valid1, less1, equal1, greater1, busy1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wide_cmp_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
      .less(less), .equal(equal), .greater(greater), .busy(busy)
   );

   wide_cmp_seq #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .data_a(data_a1), .data_b(data_b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .less(less1), .equal(equal1), .greater(greater1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: nibbles examined = position of first differing nibble from the top;
   // ordering from plain integer comparison.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int m, output logic [2:0] r);
      m = 0;
      for (int i = N - 1; i >= 0; i--) begin
         m++;
         if (a[4*i +: 4] != b[4*i +: 4]) break;
      end
`ifdef WIDE_CMP_SIGNED_EN
      if ($signed(a) < $signed(b))      r = 3'b100;
      else if ($signed(a) > $signed(b)) r = 3'b001;
      else                              r = 3'b010;
`else
      if (a < b)      r = 3'b100;
      else if (a > b) r = 3'b001;
      else            r = 3'b010;
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                         input int exp_m, input logic [2:0] exp_r);
      int lat;
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      data_a    = a;
      data_b    = b;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_a   = W'($urandom);
      data_b   = W'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < N + 2) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_m));
      chk("result_flags", {29'd0, less, equal, greater}, {29'd0, exp_r});
      for (int i = 0; i < stall; i++) begin
         in_valid = (i == 1);
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_flags", {29'd0, less, equal, greater}, {29'd0, exp_r});
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_flags", {29'd0, less, equal, greater}, 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] exp_r);
      @(negedge clk);
      data_a1    = a;
      data_b1    = b;
      in_valid1  = 1'b1;
      out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      @(posedge clk);
      #1;
      chk("n1_valid", 32'(out_valid1), 32'd1);
      chk("n1_flags", {29'd0, less1, equal1, greater1}, {29'd0, exp_r});
      @(posedge clk);
      #1;
      chk("n1_post_valid", 32'(out_valid1), 32'd0);
      chk("n1_in_ready", 32'(in_ready1), 32'd1);
   endtask

   initial begin
      int m;
      logic [2:0] r;
      logic [W-1:0] a, b;
      logic seen;

      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_outputs", {28'd0, out_valid, less, equal, greater}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(16'h1234, 16'h1234, 0, 4, 3'b010);
`ifdef WIDE_CMP_SIGNED_EN
      run_op(16'h8000, 16'h7FFF, 0, 1, 3'b100);
`else
      run_op(16'h8000, 16'h7FFF, 0, 1, 3'b001);
`endif
      run_op(16'h12A4, 16'h12B0, 0, 3, 3'b100);
      run_op(16'h0005, 16'h0003, 5, 4, 3'b001);

      // Abandon an operation with an asynchronous reset two cycles after accept.
      @(negedge clk);
      data_a    = 16'h0001;
      data_b    = 16'h0000;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {28'd0, out_valid, less, equal, greater}, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < N + 3; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);
      chk("midrst_in_ready_after", 32'(in_ready), 32'd1);

`ifdef WIDE_CMP_SIGNED_EN
      run_op1(4'h9, 4'h3, 3'b100);
`else
      run_op1(4'h9, 4'h3, 3'b001);
`endif
      run_op1(4'h3, 4'h3, 3'b010);
      run_op1(4'h2, 4'h7, 3'b100);

      for (int k = 0; k < 40; k++) begin
         a = W'($urandom);
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ W'($urandom_range(1, 15));
            2: b = a ^ W'($urandom_range(1, 255) << 4);
            default: b = W'($urandom);
         endcase
         model(a, b, m, r);
         run_op(a, b, int'($urandom_range(0, 3)), m, r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
